// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined control unit for a 5-stage RV32I core. It decodes the ID-stage
// instruction into a control bundle and carries that bundle through the
// ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards,
// inserts bubbles on flush, stall or an invalid slot, and flags illegal
// opcodes.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instrId/instrValid  ID-stage instruction and its valid qualifier
//   stallAll            global freeze; all stage registers hold
//   flushIdEx           kill the ID instruction (a bubble enters EX)
//   loadUseStall        combinational; freeze PC and IF/ID
//   ex*                 EX-stage controls, destination and illegal flag
//   memRd/memWrt/memRdAddr   MEM-stage controls and destination
//   wbRegWrt/wbMemToReg/wbRd WB-stage controls and destination
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W    = 5,
    parameter int SUPPORT_JALR  = 1,
    parameter int SUPPORT_AUIPC = 1,
    parameter int ILLEGAL_TRAP  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instrId,
    input  logic                  instrValid,
    input  logic                  stallAll,
    input  logic                  flushIdEx,
    output logic                  loadUseStall,
    output logic                  exAluSrc,
    output logic                  exAluASrcPc,
    output logic [1:0]            exAluOp,
    output logic                  exBranch,
    output logic                  exJump,
    output logic                  exJalr,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic                  exIllegal,
    output logic                  memRd,
    output logic                  memWrt,
    output logic [REG_ADDR_W-1:0] memRdAddr,
    output logic                  wbRegWrt,
    output logic [1:0]            wbMemToReg,
    output logic [REG_ADDR_W-1:0] wbRd
);

    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic [6:0]            w_op;
    logic [REG_ADDR_W-1:0] w_rd, w_rs1, w_rs2;
    logic                  w_unused_bits;

    assign w_op          = instrId[6:0];
    assign w_rd          = REG_ADDR_W'(instrId[11:7]);
    assign w_rs1         = REG_ADDR_W'(instrId[19:15]);
    assign w_rs2         = REG_ADDR_W'(instrId[24:20]);
    assign w_unused_bits = &{1'b0, instrId[31:25], instrId[14:12]};

    // Decoded bundle
    logic       w_aluSrc, w_aluASrcPc, w_branch, w_jump, w_jalr;
    logic       w_memRd, w_memWrt, w_regWrt, w_illegal, w_useRs1, w_useRs2;
    logic [1:0] w_aluOp, w_memToReg;

    always_comb begin
        w_aluSrc    = 1'b0;
        w_aluASrcPc = 1'b0;
        w_aluOp     = 2'b00;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_jalr      = 1'b0;
        w_memRd     = 1'b0;
        w_memWrt    = 1'b0;
        w_regWrt    = 1'b0;
        w_memToReg  = 2'b00;
        w_illegal   = 1'b0;
        w_useRs1    = 1'b0;
        w_useRs2    = 1'b0;
        case (w_op)
            OP_I:  begin w_aluSrc = 1'b1; w_aluOp = 2'b01; w_regWrt = 1'b1; w_useRs1 = 1'b1; end
            OP_L:  begin
                w_aluSrc = 1'b1; w_memRd = 1'b1; w_regWrt = 1'b1;
                w_memToReg = 2'b01; w_useRs1 = 1'b1;
            end
            OP_R:  begin w_aluOp = 2'b01; w_regWrt = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
            OP_S:  begin w_aluSrc = 1'b1; w_memWrt = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
            OP_SB: begin w_branch = 1'b1; w_aluOp = 2'b10; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
            OP_LUI: begin w_aluSrc = 1'b1; w_aluOp = 2'b11; w_regWrt = 1'b1; end
            OP_JAL: begin w_jump = 1'b1; w_regWrt = 1'b1; w_memToReg = 2'b10; end
            OP_AUIPC: begin
                if (SUPPORT_AUIPC != 0) begin
                    w_aluSrc = 1'b1; w_aluASrcPc = 1'b1; w_regWrt = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (SUPPORT_JALR != 0) begin
                    w_aluSrc = 1'b1; w_jump = 1'b1; w_jalr = 1'b1;
                    w_regWrt = 1'b1; w_memToReg = 2'b10; w_useRs1 = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        // Writes to x0 are discarded at decode
        if (w_rd == '0) w_regWrt = 1'b0;
    end

    // ID/EX register
    logic                  r_ex_memRd, r_ex_memWrt, r_ex_regWrt;
    logic [1:0]            r_ex_memToReg;
    // EX/MEM register
    logic                  r_mem_regWrt;
    logic [1:0]            r_mem_memToReg;

    // Load-use: a load sitting in EX whose destination is a source of the
    // instruction in ID. exRd is zero for anything that does not write.
    assign loadUseStall = instrValid && (exRd != '0) && r_ex_memRd &&
                          ((w_useRs1 && (w_rs1 == exRd)) ||
                           (w_useRs2 && (w_rs2 == exRd)));

    logic w_bubble;
    assign w_bubble = flushIdEx || loadUseStall || !instrValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exAluSrc       <= 1'b0;
            exAluASrcPc    <= 1'b0;
            exAluOp        <= 2'b00;
            exBranch       <= 1'b0;
            exJump         <= 1'b0;
            exJalr         <= 1'b0;
            exRd           <= '0;
            exIllegal      <= 1'b0;
            r_ex_memRd     <= 1'b0;
            r_ex_memWrt    <= 1'b0;
            r_ex_regWrt    <= 1'b0;
            r_ex_memToReg  <= 2'b00;
            memRd          <= 1'b0;
            memWrt         <= 1'b0;
            memRdAddr      <= '0;
            r_mem_regWrt   <= 1'b0;
            r_mem_memToReg <= 2'b00;
            wbRegWrt       <= 1'b0;
            wbMemToReg     <= 2'b00;
            wbRd           <= '0;
        end else if (!stallAll) begin
            // MEM/WB <- EX/MEM
            wbRegWrt       <= r_mem_regWrt;
            wbMemToReg     <= r_mem_memToReg;
            wbRd           <= memRdAddr;
            // EX/MEM <- ID/EX
            memRd          <= r_ex_memRd;
            memWrt         <= r_ex_memWrt;
            memRdAddr      <= exRd;
            r_mem_regWrt   <= r_ex_regWrt;
            r_mem_memToReg <= r_ex_memToReg;
            // ID/EX <- decode or bubble
            if (w_bubble) begin
                exAluSrc      <= 1'b0;
                exAluASrcPc   <= 1'b0;
                exAluOp       <= 2'b00;
                exBranch      <= 1'b0;
                exJump        <= 1'b0;
                exJalr        <= 1'b0;
                exRd          <= '0;
                exIllegal     <= 1'b0;
                r_ex_memRd    <= 1'b0;
                r_ex_memWrt   <= 1'b0;
                r_ex_regWrt   <= 1'b0;
                r_ex_memToReg <= 2'b00;
            end else begin
                exAluSrc      <= w_aluSrc;
                exAluASrcPc   <= w_aluASrcPc;
                exAluOp       <= w_aluOp;
                exBranch      <= w_branch;
                exJump        <= w_jump;
                exJalr        <= w_jalr;
                // Only real writers carry a destination, so stores/branches
                // never alias a forwarding or hazard compare.
                exRd          <= w_regWrt ? w_rd : '0;
                exIllegal     <= w_illegal && (ILLEGAL_TRAP != 0);
                r_ex_memRd    <= w_memRd;
                r_ex_memWrt   <= w_memWrt;
                r_ex_regWrt   <= w_regWrt;
                r_ex_memToReg <= w_memToReg;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrId;
    logic        instrValid, stallAll, flushIdEx;

    always #5 clk = ~clk;

    // u_dut: full configuration
    logic       loadUseStall, exAluSrc, exAluASrcPc, exBranch, exJump, exJalr, exIllegal;
    logic       memRd, memWrt, wbRegWrt;
    logic [1:0] exAluOp, wbMemToReg;
    logic [4:0] exRd, memRdAddr, wbRd;
    // u_b: no JALR, no AUIPC
    logic       lu_b, aluSrc_b, aPc_b, br_b, jmp_b, jalr_b, ill_b, mrd_b, mwr_b, wbw_b;
    logic [1:0] aluOp_b, m2r_b;
    logic [4:0] exRd_b, mra_b, wbRd_b;
    // u_c: illegal trap disabled
    logic       lu_c, aluSrc_c, aPc_c, br_c, jmp_c, jalr_c, ill_c, mrd_c, mwr_c, wbw_c;
    logic [1:0] aluOp_c, m2r_c;
    logic [4:0] exRd_c, mra_c, wbRd_c;

    pipe_ctrl_unit u_dut (
        .clk(clk), .rst_n(rst_n), .instrId(instrId), .instrValid(instrValid),
        .stallAll(stallAll), .flushIdEx(flushIdEx), .loadUseStall(loadUseStall),
        .exAluSrc(exAluSrc), .exAluASrcPc(exAluASrcPc), .exAluOp(exAluOp),
        .exBranch(exBranch), .exJump(exJump), .exJalr(exJalr), .exRd(exRd),
        .exIllegal(exIllegal), .memRd(memRd), .memWrt(memWrt), .memRdAddr(memRdAddr),
        .wbRegWrt(wbRegWrt), .wbMemToReg(wbMemToReg), .wbRd(wbRd)
    );

    pipe_ctrl_unit #(.SUPPORT_JALR(0), .SUPPORT_AUIPC(0)) u_b (
        .clk(clk), .rst_n(rst_n), .instrId(instrId), .instrValid(instrValid),
        .stallAll(stallAll), .flushIdEx(flushIdEx), .loadUseStall(lu_b),
        .exAluSrc(aluSrc_b), .exAluASrcPc(aPc_b), .exAluOp(aluOp_b),
        .exBranch(br_b), .exJump(jmp_b), .exJalr(jalr_b), .exRd(exRd_b),
        .exIllegal(ill_b), .memRd(mrd_b), .memWrt(mwr_b), .memRdAddr(mra_b),
        .wbRegWrt(wbw_b), .wbMemToReg(m2r_b), .wbRd(wbRd_b)
    );

    pipe_ctrl_unit #(.ILLEGAL_TRAP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .instrId(instrId), .instrValid(instrValid),
        .stallAll(stallAll), .flushIdEx(flushIdEx), .loadUseStall(lu_c),
        .exAluSrc(aluSrc_c), .exAluASrcPc(aPc_c), .exAluOp(aluOp_c),
        .exBranch(br_c), .exJump(jmp_c), .exJalr(jalr_c), .exRd(exRd_c),
        .exIllegal(ill_c), .memRd(mrd_c), .memWrt(mwr_c), .memRdAddr(mra_c),
        .wbRegWrt(wbw_c), .wbMemToReg(m2r_c), .wbRd(wbRd_c)
    );

    // Every output of the main instance, and the EX controls other than exIllegal
    logic [28:0] all_out;
    logic [13:0] ex_ctl, ex_ctl_b;
    assign all_out  = {loadUseStall, exAluSrc, exAluASrcPc, exAluOp, exBranch, exJump,
                       exJalr, exRd, exIllegal, memRd, memWrt, memRdAddr, wbRegWrt,
                       wbMemToReg, wbRd};
    assign ex_ctl   = {exAluSrc, exAluASrcPc, exAluOp, exBranch, exJump, exJalr, exRd, 1'b0};
    assign ex_ctl_b = {aluSrc_b, aPc_b, aluOp_b, br_b, jmp_b, jalr_b, exRd_b, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset with a valid addi x1,x0,5 in ID
        rst_n = 1'b0; instrId = 32'h00500093; instrValid = 1'b1;
        stallAll = 1'b0; flushIdEx = 1'b0;
        #12;
        chk("rst_all", 32'(all_out), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("addi_ex", {exAluSrc, exAluOp, exRd, exIllegal}, {1'b1, 2'b01, 5'd1, 1'b0});
        instrValid = 1'b0;
        tick();
        chk("addi_mem", {memRd, memWrt, memRdAddr}, {2'b00, 5'd1});
        tick();
        chk("addi_wb", {wbRegWrt, wbMemToReg, wbRd}, {1'b1, 2'b00, 5'd1});

        // 2. Load-use: lw x2,0(x1) then add x3,x2,x1
        instrId = 32'h0000A103; instrValid = 1'b1;
        tick();
        chk("lw_ex", {exAluSrc, exRd}, {1'b1, 5'd2});
        instrId = 32'h001101B3;
        #1;
        chk("lu_hi", 32'(loadUseStall), 32'h1);
        tick();
        chk("lu_bubble", 32'(ex_ctl), 32'h0);
        chk("lu_mem", {memRd, memRdAddr, loadUseStall}, {1'b1, 5'd2, 1'b0});
        tick();
        chk("add_ex", {exAluOp, exRd, loadUseStall}, {2'b01, 5'd3, 1'b0});
        chk("lw_wb", {wbRegWrt, wbMemToReg, wbRd}, {1'b1, 2'b01, 5'd2});
        instrValid = 1'b0;

        // 3. Flush: sw x2,0(x1) in EX, add in ID with flushIdEx
        instrId = 32'h0020A023; instrValid = 1'b1;
        tick();
        chk("sw_ex", {exAluSrc, exRd}, {1'b1, 5'd0});
        instrId = 32'h001101B3; flushIdEx = 1'b1;
        tick();
        chk("flush_ex", {ex_ctl, exIllegal}, 15'h0);
        chk("flush_mem", {memWrt, memRd}, 2'b10);
        flushIdEx = 1'b0;

        // 4. stallAll for 3 cycles with lui x6 in EX and jal x1 waiting in ID
        instrId = 32'h12345337;
        tick();
        chk("lui_ex", {exAluSrc, exAluOp, exRd}, {1'b1, 2'b11, 5'd6});
        instrId = 32'h008000EF; stallAll = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_frz", {exAluOp, exRd, exJump, memWrt, memRdAddr, wbRegWrt, wbRd},
                {2'b11, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0});
        end
        stallAll = 1'b0;
        tick();
        chk("jal_ex", {exJump, exJalr, exRd, memRdAddr}, {1'b1, 1'b0, 5'd1, 5'd6});
        instrValid = 1'b0;
        tick();
        chk("lui_wb", {wbRegWrt, wbRd, memRdAddr}, {1'b1, 5'd6, 5'd1});
        tick();
        chk("jal_wb", {wbRegWrt, wbMemToReg, wbRd}, {1'b1, 2'b10, 5'd1});

        // 5. addi x0,x0,0 never writes
        instrId = 32'h00000013; instrValid = 1'b1;
        tick();
        chk("x0_ex", 32'(exRd), 32'h0);
        instrValid = 1'b0;
        tick(); tick();
        chk("x0_wb", 32'(wbRegWrt), 32'h0);

        // jalr x1,0(x1): decoded in u_dut, illegal in u_b
        instrId = 32'h000080E7; instrValid = 1'b1;
        tick();
        chk("jalr_ex", {exAluSrc, exJump, exJalr, exRd, exIllegal}, {3'b111, 5'd1, 1'b0});
        chk("jalr_off_ill", 32'(ill_b), 32'h1);
        chk("jalr_off_ctl", 32'(ex_ctl_b), 32'h0);

        // auipc x7: decoded in u_dut, illegal in u_b
        instrId = 32'h00000397;
        tick();
        chk("auipc_ex", {exAluSrc, exAluASrcPc, exAluOp, exRd}, {2'b11, 2'b00, 5'd7});
        chk("auipc_off", {ill_b, ex_ctl_b}, 15'h4000);

        // 6. Illegal opcode
        instrId = 32'hFFFFFFFF;
        tick();
        chk("ill_ex", {exIllegal, ex_ctl}, 15'h4000);
        chk("ill_notrap", 32'(ill_c), 32'h0);
        instrValid = 1'b0;
        tick();
        chk("ill_mem", {exIllegal, memRd, memWrt, memRdAddr}, 8'h0);
        tick();
        chk("ill_wb", {wbRegWrt, wbRd}, 6'h0);

        // Async reset mid-stream with a load-use pending
        instrId = 32'h0000A103; instrValid = 1'b1;
        tick();
        instrId = 32'h001101B3;
        #1;
        chk("lu_pre_rst", 32'(loadUseStall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_all", 32'(all_out), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ex", {exAluOp, exRd}, {2'b01, 5'd3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
